riscv_run_ctrl: RTL and testbench
=================================

Name: riscv_run_ctrl

Overview:
Synthesisable run controller for the RISC-V cores, replacing the ad hoc reset/cycle-limit logic in benches and FPGA top-levels. It does three things:
- Sequences a stretched core reset.
- Counts cycles and retired instructions.
- Detects program completion (EBREAK, ECALL or a self-loop) or a watchdog timeout, then freezes the core and reports the cause.
It sits between the board/bench reset and any core (single-cycle or pipelined) that exposes a retire strobe and PC.

Parameters:
ADDR_WIDTH, 32, width of the retired PC compared for loop detection.
CNT_WIDTH, 16, width of the cycle and instruction counters.
RESET_CYCLES, 2, number of cycles core_res_n is held low after res_n deasserts (>=1).
MAX_CYCLES, 112, watchdog limit in RUN cycles (1 .. 2^CNT_WIDTH-1).
LOOP_LIMIT, 4, consecutive retires at the same PC that declare a self-loop halt (>=2).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
res_n  in  1  asynchronous active-low reset.
restart  in  1  single-cycle pulse; re-runs the program from DONE or TIMEOUT.
retire_valid  in  1  core retired one instruction this cycle.
retire_pc  in  ADDR_WIDTH  PC of the retired instruction.
retire_instr  in  32  encoding of the retired instruction.
core_res_n  out  1  registered active-low reset to the core.
core_en  out  1  core clock-enable; high only in RUN.
done  out  1  sticky; program completed.
timeout  out  1  sticky; watchdog expired.
halt_cause  out  2  0 none, 1 EBREAK, 2 ECALL, 3 self-loop.
cycle_cnt  out  CNT_WIDTH  RUN cycles elapsed.
instr_cnt  out  CNT_WIDTH  instructions retired in RUN.

Behaviour:
- Reset value while res_n is low (asynchronous): state RST_HOLD, core_res_n=0, core_en=0, done=0, timeout=0, halt_cause=0, cycle_cnt=0, instr_cnt=0, hold counter=0, loop_cnt=0, pc_valid=0.
- The FSM has four states: RST_HOLD, RUN, DONE, TMO.
- RST_HOLD:
  - The hold counter increments each cycle.
  - When it reaches RESET_CYCLES-1, the next edge moves to RUN and sets core_res_n=1 and core_en=1.
  - core_res_n therefore rises on rising edge number RESET_CYCLES after res_n deasserts.
- RUN:
  - cycle_cnt increments every cycle.
  - instr_cnt increments on retire_valid and saturates at all-ones.
- Halt checks in RUN, evaluated only when retire_valid=1:
  - retire_instr==32'h00100073 -> DONE, cause 1.
  - retire_instr==32'h00000073 -> DONE, cause 2.
  - If pc_valid and retire_pc equals the last retired PC, loop_cnt increments. Otherwise loop_cnt clears to 0. On every retire, the last PC is updated and pc_valid is set.
  - The transition to DONE with cause 3 occurs on the retire where loop_cnt+1 reaches LOOP_LIMIT-1, i.e. the LOOP_LIMIT-th consecutive retire at the same PC.
- Watchdog: if cycle_cnt==MAX_CYCLES-1 and no halt condition holds this cycle, move to TMO with timeout=1 and halt_cause=0.
- Priority when events coincide in one cycle: EBREAK > ECALL > self-loop > timeout. A halt and a timeout in the same cycle yields done=1 and timeout=0.
- Effects of the halting retire: it is counted in instr_cnt, and cycle_cnt increments on that edge.
- DONE/TMO:
  - core_en=0 and core_res_n stays 1, so core architectural state remains inspectable.
  - Counters, done, timeout and halt_cause are frozen.
  - retire_valid is ignored.
- restart:
  - In DONE/TMO, the next edge goes to RST_HOLD, clears done, timeout, halt_cause, counters, loop_cnt and pc_valid, and drives core_res_n=0.
  - restart is ignored in RUN and RST_HOLD.
- All outputs are registered; there is no combinational path from inputs to outputs.
- res_n assertion mid-RUN or in any state forces the reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset sequencing: res_n low for 3 cycles, then high, RESET_CYCLES=2 -> core_res_n=0 for 2 edges after deassert, rises with core_en on the 2nd edge; cycle_cnt=0 at that point.
2. EBREAK halt: retire 5 distinct PCs 0,4,8,12,16, the last with instr 32'h00100073 -> done=1, halt_cause=1, instr_cnt=5, core_en=0 next cycle; further retires do not change counters.
3. Self-loop: LOOP_LIMIT=4, retires at PC 0x20 (instr 32'h0000006F) every cycle -> done=1, halt_cause=3 after the 4th retire, instr_cnt=4.
4. Timeout: MAX_CYCLES=112, retire_valid=0 throughout -> timeout=1, done=0, cycle_cnt=112, halt_cause=0.
5. Coincidence: ECALL retired in the cycle with cycle_cnt=MAX_CYCLES-1 -> done=1, halt_cause=2, timeout=0.
6. Restart and async reset: restart pulse in DONE -> RST_HOLD with all status cleared, then a normal run. res_n pulsed low mid-RUN, between clock edges -> core_res_n=0 and counters=0 immediately.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl
//   Run controller for a RISC-V core. It stretches the core reset, counts
//   RUN cycles and retired instructions, and stops the core when the program
//   ends (EBREAK, ECALL or a self-loop) or when a watchdog expires. After a
//   stop, the cause is held until a restart pulse or res_n.
//
// Ports
//   clk           in   system clock, rising edge
//   res_n         in   asynchronous active-low reset
//   restart       in   one-cycle pulse; re-runs the program from DONE/TMO
//   retire_valid  in   core retired one instruction this cycle
//   retire_pc     in   PC of the retired instruction
//   retire_instr  in   encoding of the retired instruction
//   core_res_n    out  registered active-low core reset
//   core_en       out  core clock enable, high only in RUN
//   done          out  sticky, program completed
//   timeout       out  sticky, watchdog expired
//   halt_cause    out  0 none, 1 EBREAK, 2 ECALL, 3 self-loop
//   cycle_cnt     out  RUN cycles elapsed
//   instr_cnt     out  instructions retired in RUN (saturating)
//
// Retire interface: retire_valid qualifies retire_pc/retire_instr in the
// same cycle. There is no back-pressure. A retire is consumed on every
// RUN cycle in which retire_valid is high, and it is ignored in all other
// states.
module riscv_run_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 112,
  parameter int LOOP_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  restart,
  input  logic                  retire_valid,
  input  logic [ADDR_WIDTH-1:0] retire_pc,
  input  logic [31:0]           retire_instr,
  output logic                  core_res_n,
  output logic                  core_en,
  output logic                  done,
  output logic                  timeout,
  output logic [1:0]            halt_cause,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instr_cnt
);

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_TMO      = 2'd3;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_ECALL  = 2'd2;
  localparam logic [1:0] CAUSE_LOOP   = 2'd3;

  // The hold counter only needs to reach RESET_CYCLES-1. loop_cnt never
  // exceeds LOOP_LIMIT-1, because the run halts when it would.
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int LOOP_W = $clog2(LOOP_LIMIT);

  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [LOOP_W-1:0]    LOOP_LAST = LOOP_W'(LOOP_LIMIT - 2);
  localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

  logic [1:0]            state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [LOOP_W-1:0]     loop_cnt;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic                  pc_valid;

  logic       same_pc;
  logic       wdog_hit;
  logic [1:0] halt_code;

  assign same_pc  = pc_valid && (retire_pc == last_pc);
  assign wdog_hit = (cycle_cnt == WDOG_LAST);

  // The halt cause follows a fixed priority. loop_cnt counts earlier
  // matching retires, so loop_cnt == LOOP_LIMIT-2 together with another
  // match means this is the LOOP_LIMIT-th consecutive retire at that PC.
  always_comb begin
    halt_code = CAUSE_NONE;
    if (retire_valid) begin
      if (retire_instr == INSTR_EBREAK)
        halt_code = CAUSE_EBREAK;
      else if (retire_instr == INSTR_ECALL)
        halt_code = CAUSE_ECALL;
      else if (same_pc && (loop_cnt == LOOP_LAST))
        halt_code = CAUSE_LOOP;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= ST_RST_HOLD;
      hold_cnt   <= '0;
      loop_cnt   <= '0;
      last_pc    <= '0;
      pc_valid   <= 1'b0;
      core_res_n <= 1'b0;
      core_en    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      case (state)
        ST_RST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            core_res_n <= 1'b1;
            core_en    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_RUN: begin
          // The halting retire is still counted, and its cycle is too.
          cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
          if (retire_valid) begin
            if (instr_cnt != '1)
              instr_cnt <= instr_cnt + CNT_WIDTH'(1);
            loop_cnt <= same_pc ? (loop_cnt + LOOP_W'(1)) : '0;
            last_pc  <= retire_pc;
            pc_valid <= 1'b1;
          end
          if (halt_code != CAUSE_NONE) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            halt_cause <= halt_code;
            core_en    <= 1'b0;
          end else if (wdog_hit) begin
            state   <= ST_TMO;
            timeout <= 1'b1;
            core_en <= 1'b0;
          end
        end

        default: begin
          // DONE and TMO keep the core out of reset so its state stays
          // readable. Only restart leaves these states.
          if (restart) begin
            state      <= ST_RST_HOLD;
            hold_cnt   <= '0;
            loop_cnt   <= '0;
            pc_valid   <= 1'b0;
            core_res_n <= 1'b0;
            core_en    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Testbench for riscv_run_ctrl. Inputs are driven on the falling edge and
// outputs are checked on the falling edge. Each program is a per-RUN-cycle
// table of retires. A reference model computes the expected outcome of the
// table straight from the halting rules.
module tb_riscv_run_ctrl;

  localparam int AW    = 32;
  localparam int CW    = 16;
  localparam int RC    = 2;
  localparam int MAXC  = 112;
  localparam int LOOPL = 4;
  localparam int EW    = 2 + 1 + 1 + CW + CW;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic          clk;
  logic          res_n;
  logic          restart;
  logic          retire_valid;
  logic [AW-1:0] retire_pc;
  logic [31:0]   retire_instr;
  logic          core_res_n;
  logic          core_en;
  logic          done;
  logic          timeout;
  logic [1:0]    halt_cause;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instr_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  // Program table, indexed by RUN cycle number.
  logic          p_valid [MAXC];
  logic [AW-1:0] p_pc    [MAXC];
  logic [31:0]   p_instr [MAXC];

  riscv_run_ctrl #(
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW),
    .RESET_CYCLES(RC),
    .MAX_CYCLES  (MAXC),
    .LOOP_LIMIT  (LOOPL)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .restart     (restart),
    .retire_valid(retire_valid),
    .retire_pc   (retire_pc),
    .retire_instr(retire_instr),
    .core_res_n  (core_res_n),
    .core_en     (core_en),
    .done        (done),
    .timeout     (timeout),
    .halt_cause  (halt_cause),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_res_n"}, 32'(core_res_n), 0);
    check({tag, "_core_en"},    32'(core_en), 0);
    check({tag, "_done"},       32'(done), 0);
    check({tag, "_timeout"},    32'(timeout), 0);
    check({tag, "_cause"},      32'(halt_cause), 0);
    check({tag, "_cycle"},      32'(cycle_cnt), 0);
    check({tag, "_instr"},      32'(instr_cnt), 0);
  endtask

  // ---------------- reference model ----------------
  // A run ends at the first EBREAK/ECALL retire, or at the retire that
  // completes a streak of LOOPL back-to-back retires at one PC. Cycles with
  // no retire do not break a streak. If nothing ends the run, the watchdog
  // stops it after MAXC cycles.
  function automatic logic [EW-1:0] model_run();
    logic [1:0]    cause  = 2'd0;
    int            cycles = MAXC;
    int            instrs = 0;
    int            streak = 0;
    logic [AW-1:0] last   = '0;
    for (int k = 0; k < MAXC; k++) begin
      if (p_valid[k]) begin
        instrs++;
        if (streak > 0 && p_pc[k] == last) streak++;
        else streak = 1;
        last = p_pc[k];
        if (p_instr[k] == EBREAK)      cause = 2'd1;
        else if (p_instr[k] == ECALL)  cause = 2'd2;
        else if (streak == LOOPL)      cause = 2'd3;
        if (cause != 2'd0) begin
          cycles = k + 1;
          break;
        end
      end
    end
    return {cause, (cause != 2'd0), (cause == 2'd0), CW'(cycles), CW'(instrs)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_prog();
    for (int k = 0; k < MAXC; k++) begin
      p_valid[k] = 1'b0;
      p_pc[k]    = '0;
      p_instr[k] = NOP;
    end
  endtask

  task automatic rand_prog();
    logic [AW-1:0] pc = 32'h100;
    for (int k = 0; k < MAXC; k++) begin
      int r = $urandom_range(0, 99);
      p_valid[k] = (r < 70);
      if ($urandom_range(0, 2) != 0)
        pc = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      p_pc[k] = pc;
      r = $urandom_range(0, 199);
      if (r == 0)      p_instr[k] = EBREAK;
      else if (r == 1) p_instr[k] = ECALL;
      else             p_instr[k] = {$urandom} | 32'h0000_0003 | 32'h0000_1000;
    end
  endtask

  // Optional restart pulse, then a bounded wait for RUN.
  task automatic start_run(input bit do_restart, input string tag);
    int n = 0;
    if (do_restart) begin
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check_idle({tag, "_after_restart"});
    end
    while (core_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_run_entry"}, 32'(core_en), 1);
    check({tag, "_run_res_n"}, 32'(core_res_n), 1);
    check({tag, "_run_cycle0"}, 32'(cycle_cnt), 0);
  endtask

  // Play the program table until the DUT leaves RUN, with a bounded loop.
  // Afterwards, check the outcome against the queued model result and
  // confirm that extra retires leave it unchanged.
  task automatic play(input string tag);
    logic [EW-1:0] e;
    int k = 0;
    exp_q.push_back(model_run());
    while (core_en === 1'b1 && k < MAXC + 4) begin
      retire_valid = (k < MAXC) ? p_valid[k] : 1'b0;
      retire_pc    = (k < MAXC) ? p_pc[k]    : '0;
      retire_instr = (k < MAXC) ? p_instr[k] : NOP;
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    for (int rep = 0; rep < 2; rep++) begin
      check({tag, "_core_en"},  32'(core_en), 0);
      check({tag, "_cause"},    32'(halt_cause), 32'(e[EW-1 -: 2]));
      check({tag, "_done"},     32'(done), 32'(e[2*CW+1]));
      check({tag, "_timeout"},  32'(timeout), 32'(e[2*CW]));
      check({tag, "_cycle"},    32'(cycle_cnt), 32'(e[2*CW-1 -: CW]));
      check({tag, "_instr"},    32'(instr_cnt), 32'(e[CW-1:0]));
      check({tag, "_res_n_hi"}, 32'(core_res_n), 1);
      // Throw retires at the stopped DUT. The outcome must stay frozen.
      for (int j = 0; j < 3; j++) begin
        retire_valid = 1'b1;
        retire_pc    = 32'h20;
        retire_instr = (j == 0) ? EBREAK : NOP;
        @(negedge clk);
      end
      retire_valid = 1'b0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    res_n        = 1'b0;
    restart      = 1'b0;
    retire_valid = 1'b0;
    retire_pc    = '0;
    retire_instr = NOP;

    // 1. Reset sequencing.
    repeat (3) @(negedge clk);
    check_idle("reset");
    res_n = 1'b1;
    @(negedge clk);
    check("hold_edge1_res_n", 32'(core_res_n), 0);
    check("hold_edge1_en",    32'(core_en), 0);
    @(negedge clk);
    check("hold_edge2_res_n", 32'(core_res_n), 1);
    check("hold_edge2_en",    32'(core_en), 1);
    check("hold_edge2_cycle", 32'(cycle_cnt), 0);

    // 2. EBREAK after five distinct PCs.
    clear_prog();
    for (int k = 0; k < 5; k++) begin
      p_valid[k] = 1'b1;
      p_pc[k]    = 32'(k * 4);
    end
    p_instr[4] = EBREAK;
    start_run(1'b0, "ebreak");
    play("ebreak");
    check("ebreak_cause_const", 32'(halt_cause), 1);
    check("ebreak_instr_const", 32'(instr_cnt), 5);

    // 3. Self-loop at PC 0x20.
    clear_prog();
    for (int k = 0; k < MAXC; k++) begin
      p_valid[k] = 1'b1;
      p_pc[k]    = 32'h20;
      p_instr[k] = 32'h0000_006F;
    end
    start_run(1'b1, "loop");
    play("loop");
    check("loop_cause_const", 32'(halt_cause), 3);
    check("loop_instr_const", 32'(instr_cnt), 4);

    // 4. Watchdog with no retires.
    clear_prog();
    start_run(1'b1, "tmo");
    play("tmo");
    check("tmo_flag_const",  32'(timeout), 1);
    check("tmo_cycle_const", 32'(cycle_cnt), MAXC);

    // 5. ECALL coinciding with the last watchdog cycle.
    clear_prog();
    p_valid[MAXC-1] = 1'b1;
    p_pc[MAXC-1]    = 32'h40;
    p_instr[MAXC-1] = ECALL;
    start_run(1'b1, "coinc");
    play("coinc");
    check("coinc_cause_const",   32'(halt_cause), 2);
    check("coinc_timeout_const", 32'(timeout), 0);

    // 6. Asynchronous reset in the middle of RUN, between clock edges.
    start_run(1'b1, "async");
    for (int k = 0; k < 6; k++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'(k * 4);
      retire_instr = NOP;
      @(negedge clk);
    end
    retire_valid = 1'b0;
    #2;
    res_n = 1'b0;
    #1;
    check_idle("async");
    @(negedge clk);
    res_n = 1'b1;
    start_run(1'b0, "post_async");
    clear_prog();
    p_valid[2] = 1'b1;
    p_instr[2] = EBREAK;
    play("post_async");

    // 7. Random programs against the model.
    for (int t = 0; t < 25; t++) begin
      rand_prog();
      start_run(1'b1, "rand");
      play($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
